// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: a req/gnt request phase followed by
// an rvalid read-response phase. The LSU drives the master side.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [3:0]            dmem_be;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  dmem_gnt;
  logic                  dmem_rvalid;
  logic [DATA_WIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit. Accepts one access from the execute stage, formats
// byte enables and lane-replicated store data, runs the req/gnt/rvalid memory
// handshake, and returns sign/zero-extended load data. Misaligned and illegal
// accesses are reported without issuing a memory request. The upstream stages
// are stalled while an access is in flight; a one-cycle done_q window lets the
// held instruction retire without being accepted a second time.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [2:0]            ex_funct3,
  input  logic [ADDR_WIDTH-1:0] ex_addr,
  input  logic [DATA_WIDTH-1:0] ex_wdata,
  output logic                  lsu_stall,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] wb_rdata,
  output logic                  misalign_exc,
  output logic                  illegal_exc,
  output logic [ADDR_WIDTH-1:0] exc_addr,
  load_store_unit_if.master     dmem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  state_t state, state_nxt;

  logic                  done_q;
  logic                  access;
  logic                  accept;
  logic                  illegal;
  logic                  misalign;
  logic                  issue;
  logic                  store_done;
  logic                  load_done;
  logic                  req_on;

  // Access captured at acceptance
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [2:0]            funct3_p1;
  logic                  we_p1;
  logic [3:0]            be_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;

  // Only LB/LH/LW/LBU/LHU and SB/SH/SW exist; read+write together is malformed.
  function automatic logic is_illegal(input logic rd, input logic wr,
                                      input logic [2:0] f3);
    if (rd && wr) return 1'b1;
    if (rd) return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    return f3[2] || (f3 == 3'b011);
  endfunction

  // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word.
  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3,
                                          input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_data(
      input logic [2:0] f3, input logic [DATA_WIDTH-1:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Pick the addressed lane, then sign- or zero-extend by funct3[2].
  function automatic logic [DATA_WIDTH-1:0] load_extend(
      input logic [2:0] f3, input logic [1:0] off,
      input logic [DATA_WIDTH-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  assign access     = ex_valid & (ex_mem_read | ex_mem_write);
  assign accept     = (state == IDLE) & access & ~done_q;
  assign illegal    = is_illegal(ex_mem_read, ex_mem_write, ex_funct3);
  assign misalign   = is_misaligned(ex_funct3, ex_addr[1:0]);
  assign issue      = accept & ~illegal & ~misalign;
  assign store_done = (state == REQ) & dmem.dmem_gnt & we_p1;
  assign load_done  = (state == WAIT_R) & dmem.dmem_rvalid;
  assign req_on     = (state == REQ);

  // Request signals are only driven while in REQ, so they hold steady until gnt.
  assign dmem.dmem_req   = req_on;
  assign dmem.dmem_we    = req_on & we_p1;
  assign dmem.dmem_addr  = req_on ? {addr_p1[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign dmem.dmem_be    = req_on ? be_p1 : 4'b0000;
  assign dmem.dmem_wdata = req_on ? wdata_p1 : '0;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and the upstream stall
  always_comb begin
    state_nxt = state;
    lsu_stall = (state != IDLE) | accept;
    case (state)
      IDLE:    if (issue) state_nxt = REQ;
      REQ:     if (dmem.dmem_gnt) state_nxt = we_p1 ? IDLE : WAIT_R;
      WAIT_R:  if (dmem.dmem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Completion and exception pulses, plus the one-cycle retire window
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q       <= 1'b0;
      wb_valid     <= 1'b0;
      illegal_exc  <= 1'b0;
      misalign_exc <= 1'b0;
    end else begin
      wb_valid     <= store_done | load_done;
      illegal_exc  <= accept & illegal;
      misalign_exc <= accept & ~illegal & misalign;
      done_q       <= store_done | load_done | (accept & (illegal | misalign));
    end
  end

  // Result registers: extended load data and faulting address
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_rdata <= '0;
      exc_addr <= '0;
    end else begin
      if (load_done) wb_rdata <= load_extend(funct3_p1, addr_p1[1:0], dmem.dmem_rdata);
      if (accept & (illegal | misalign)) exc_addr <= ex_addr;
    end
  end

  // ---- stage p1: capture the accepted access ----
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1   <= ex_addr;
      funct3_p1 <= ex_funct3;
      we_p1     <= ex_mem_write;
      be_p1     <= ex_mem_write ? store_be(ex_funct3, ex_addr[1:0]) : 4'b1111;
      wdata_p1  <= store_data(ex_funct3, ex_wdata);
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage directly downstream of the ALU. Takes the ALU result as the effective address and performs RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a req/gnt/rvalid data-memory port.
- Generates byte enables and lane-replicated store data. Extracts and sign/zero-extends load data.
- Stalls the pipeline while an access is outstanding.
- Flags misaligned and illegal accesses without touching memory.

Parameters:
- ADDR_WIDTH, 32, effective/memory address width.
- DATA_WIDTH, 32, data width; only 32 is supported (4 byte lanes).

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- ex_valid  input  1  instruction in stage is valid
- ex_mem_read  input  1  load instruction
- ex_mem_write  input  1  store instruction
- ex_funct3  input  3  RV32I load/store funct3
- ex_addr  input  ADDR_WIDTH  effective address (ALU result)
- ex_wdata  input  DATA_WIDTH  store data (rs2)
- lsu_stall  output  1  hold upstream stages (combinational)
- wb_valid  output  1  one-cycle pulse: access complete
- wb_rdata  output  DATA_WIDTH  extended load data, qualified by wb_valid & load
- misalign_exc  output  1  one-cycle pulse: misaligned access
- illegal_exc  output  1  one-cycle pulse: illegal access
- exc_addr  output  ADDR_WIDTH  faulting address, qualified by exception pulses
- dmem_req  output  1  memory request
- dmem_we  output  1  write request
- dmem_addr  output  ADDR_WIDTH  word-aligned address ({ex_addr[ADDR_WIDTH-1:2],2'b00})
- dmem_be  output  4  byte enables
- dmem_wdata  output  DATA_WIDTH  lane-replicated store data
- dmem_gnt  input  1  request accepted this cycle
- dmem_rvalid  input  1  read data valid
- dmem_rdata  input  DATA_WIDTH  read word

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - All outputs 0: dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_valid, wb_rdata, misalign_exc, illegal_exc, exc_addr.
  - Internal done_q=0.
- Access: an access is ex_valid & (ex_mem_read | ex_mem_write).
  - Accepted only in IDLE with done_q=0.
  - Address, funct3, direction and formatted store data are captured on acceptance.
- Illegal access (checked at acceptance):
  - read & write both high, or
  - load funct3 in {011,110,111}, or
  - store funct3 not in {000,001,010}.
  - Response: no request; next cycle illegal_exc=1, exc_addr=ex_addr, done_q=1.
- Misaligned access (checked at acceptance, legal accesses only):
  - Halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Response: no request; next cycle misalign_exc=1, exc_addr=ex_addr, done_q=1.
  - Illegal has priority over misaligned.
- FSM, IDLE:
  - On a legal, aligned acceptance, go to REQ. dmem_req=1 from the next cycle.
- FSM, REQ:
  - dmem_req held 1; addr/be/we/wdata held stable until dmem_gnt.
  - On gnt, a store goes to IDLE with wb_valid=1 and done_q=1 the next cycle.
  - On gnt, a load goes to WAIT_R; dmem_req drops the next cycle.
- FSM, WAIT_R:
  - On dmem_rvalid, go to IDLE. Next cycle: wb_valid=1, wb_rdata=extended data, done_q=1.
- Store formatting:
  - SB: be=4'b0001<<addr[1:0]; wdata={4{wdata[7:0]}}.
  - SH: be=addr[1]?1100:0011; wdata={2{wdata[15:0]}}.
  - SW: be=1111; wdata unchanged.
  - Loads drive dmem_be=1111 and dmem_we=0.
- Load extraction: select the byte/half by the captured addr[1:0]/addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
- lsu_stall = (state!=IDLE) | (state==IDLE & access & !done_q).
  - In the completion cycle (done_q=1), stall is 0 and the held instruction retires.
  - done_q clears after one cycle.
  - Back-to-back accesses therefore incur exactly one issue cycle plus memory latency each; no re-issue of a completed access.
- Latency (gnt same cycle as first req, rvalid one cycle later):
  - Load: stall high 3 cycles; wb_valid in cycle 4 after acceptance.
  - Store: stall high 2 cycles; wb_valid in cycle 3 after acceptance.
- Non-access cycles: ex_valid=0 or neither read/write never stalls and produces no pulses.
- Stray signals:
  - dmem_rvalid outside WAIT_R is ignored.
  - dmem_gnt outside REQ is ignored.
  - rvalid in the same cycle as gnt is not accepted; it must arrive ≥1 cycle after gnt.
- Reset mid-operation: returns to IDLE immediately and drops any outstanding request/response. A late rvalid after reset is ignored.
- Ordering: at most one outstanding access.

Test Plan:
- LB, addr=0x1003, dmem_rdata=0x80FF_1234 → wb_rdata=0xFFFF_FF80, dmem_addr=0x1000, dmem_be=1111, one wb_valid pulse.
- LHU, addr=0x2002, rdata=0xBEEF_0000 → wb_rdata=0x0000_BEEF. LH at same address → 0xFFFF_BEEF.
- SH, addr=0x3002, wdata=0x1234_ABCD, gnt delayed 3 cycles → dmem_be=1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, request signals stable across all 4 req cycles, lsu_stall high until wb_valid.
- LW, addr=0x4001 → no dmem_req, misalign_exc=1 for one cycle, exc_addr=0x4001. Read&write both high → illegal_exc=1 only.
- Load in WAIT_R, reset asserted one cycle, then rvalid → all outputs 0, state IDLE, no wb_valid.
- SW then LW back-to-back with gnt/rvalid immediate → two dmem_req transactions, exactly two wb_valid pulses, no duplicate request for either instruction.
